// File: rtl/alu_exec_mdu_pkg.sv
// Shared encodings for the execute stage: aluop, funct, aluctr codes, MDU FSM states.
package mips_alu_pkg;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [3:0] CTRL_AND     = 4'b0000;
    localparam logic [3:0] CTRL_OR      = 4'b0001;
    localparam logic [3:0] CTRL_ADD     = 4'b0010;
    localparam logic [3:0] CTRL_MDU     = 4'b0011;
    localparam logic [3:0] CTRL_SUB     = 4'b0110;
    localparam logic [3:0] CTRL_SLT     = 4'b0111;
    localparam logic [3:0] CTRL_SLTU    = 4'b1000;
    localparam logic [3:0] CTRL_NOR     = 4'b1100;
    localparam logic [3:0] CTRL_MFHI    = 4'b1101;
    localparam logic [3:0] CTRL_MFLO    = 4'b1110;
    localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_e;

    // ALU control decode from the main decoder's aluop and the R-type funct field.
    function automatic logic [3:0] alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
        logic [3:0] c;
        c = CTRL_ILLEGAL;
        case (aluop)
            ALUOP_MEM, ALUOP_ADDI: c = CTRL_ADD;
            ALUOP_BEQ:             c = CTRL_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU:                    c = CTRL_ADD;
                    FN_SUB, FN_SUBU:                    c = CTRL_SUB;
                    FN_AND:                             c = CTRL_AND;
                    FN_OR:                              c = CTRL_OR;
                    FN_NOR:                             c = CTRL_NOR;
                    FN_SLT:                             c = CTRL_SLT;
                    FN_SLTU:                            c = CTRL_SLTU;
                    FN_MFHI:                            c = CTRL_MFHI;
                    FN_MFLO:                            c = CTRL_MFLO;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: c = CTRL_MDU;
                    default:                            c = CTRL_ILLEGAL;
                endcase
            end
            default: c = CTRL_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_exec_mdu_if.sv
// Decode-to-execute bus: operation in, result / HI / LO / status out.
interface alu_exec_mdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       aluop;
    logic [5:0]       funct;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       aluctr;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output in_valid, aluop, funct, op_a, op_b,
        input  in_ready, aluctr, out_valid, result, zero, illegal, hi, lo, busy
    );

    modport slave (
        input  in_valid, aluop, funct, op_a, op_b,
        output in_ready, aluctr, out_valid, result, zero, illegal, hi, lo, busy
    );
endinterface

// File: rtl/alu_exec_mdu_mdu_iter.sv
// Iterative multiply/divide: shift-add multiply, restoring divide, one bit per cycle,
// magnitudes internally with a sign fixup in the final cycle.
module mdu_iter
    import mips_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,    // 00 mult, 01 multu, 10 div, 11 divu
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             idle_o,
    output logic             done_o,  // high during FIX; hi_o/lo_o valid then
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;      // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   m_q, m_d;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   a_q, a_d;      // raw op_a, needed for divide-by-zero hi
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;  // negate product / quotient
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;

    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign sgn_a = ~op_i[0] & a_i[WIDTH-1];
    assign sgn_b = ~op_i[0] & b_i[WIDTH-1];
    assign mag_a = sgn_a ? -a_i : a_i;
    assign mag_b = sgn_b ? -b_i : b_i;

    assign mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? m_q : {WIDTH{1'b0}})};
    assign div_shift = p_q[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_shift >= {1'b0, m_q};
    assign div_diff  = div_shift[WIDTH-1:0] - m_q;

    assign prod_fix = neg_q ? -p_q : p_q;
    assign quo_fix  = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

    assign idle_o = (state_q == ST_IDLE);
    assign done_o = (state_q == ST_FIX);
    assign hi_o   = is_div_q ? (dz_q ? a_q : rem_fix) : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_o   = is_div_q ? (dz_q ? '1 : quo_fix) : prod_fix[WIDTH-1:0];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            m_q      <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            m_q      <= m_d;
            a_q      <= a_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
        end
    end

    // Next state: load on start, one iteration per cycle, fixup in FIX.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        m_d      = m_q;
        a_d      = a_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    p_d      = {{WIDTH{1'b0}}, mag_a};
                    m_d      = mag_b;
                    a_d      = a_i;
                    is_div_d = op_i[1];
                    neg_d    = sgn_a ^ sgn_b;
                    rneg_d   = sgn_a;
                    dz_d     = (b_i == '0);
                    cnt_d    = '0;
                    state_d  = op_i[1] ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                p_d   = {mul_sum, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_FIX;
            end
            ST_DIV: begin
                p_d   = div_ge ? {div_diff, p_q[WIDTH-2:0], 1'b1}
                               : {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/alu_exec_mdu.sv
// Execute stage: ALU control decode, registered single-cycle ALU, HI/LO fed by mdu_iter.
module alu_exec_mdu
    import mips_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_mdu_if.slave  bus
);
    logic [3:0]       ctrl;
    logic             accept, start;
    logic [WIDTH-1:0] alu_res;

    logic [3:0]       aluctr_q, aluctr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic             illegal_q, illegal_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             mdu_idle, mdu_done;
    logic [WIDTH-1:0] mdu_hi, mdu_lo;

    assign ctrl   = alu_decode(bus.aluop, bus.funct);
    assign accept = bus.in_valid && mdu_idle;
    assign start  = accept && (ctrl == CTRL_MDU);

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .op_i    (bus.funct[1:0]),
        .a_i     (bus.op_a),
        .b_i     (bus.op_b),
        .idle_o  (mdu_idle),
        .done_o  (mdu_done),
        .hi_o    (mdu_hi),
        .lo_o    (mdu_lo)
    );

    // Single-cycle ALU result for the decoded control.
    always_comb begin
        alu_res = '0;
        case (ctrl)
            CTRL_ADD:  alu_res = bus.op_a + bus.op_b;
            CTRL_SUB:  alu_res = bus.op_a - bus.op_b;
            CTRL_AND:  alu_res = bus.op_a & bus.op_b;
            CTRL_OR:   alu_res = bus.op_a | bus.op_b;
            CTRL_NOR:  alu_res = ~(bus.op_a | bus.op_b);
            CTRL_SLT:  alu_res = WIDTH'($signed(bus.op_a) < $signed(bus.op_b));
            CTRL_SLTU: alu_res = WIDTH'(bus.op_a < bus.op_b);
            CTRL_MFHI: alu_res = hi_q;
            CTRL_MFLO: alu_res = lo_q;
            default:   alu_res = '0;
        endcase
    end

    // Output register next-state; status flags are single-cycle pulses.
    always_comb begin
        aluctr_d    = aluctr_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
        zero_d      = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        if (accept) begin
            aluctr_d = ctrl;
            if (ctrl != CTRL_MDU) begin
                result_d    = alu_res;
                out_valid_d = 1'b1;
                illegal_d   = (ctrl == CTRL_ILLEGAL);
                zero_d      = (alu_res == '0);
            end
        end
        if (mdu_done) begin
            hi_d = mdu_hi;
            lo_d = mdu_lo;
        end
    end

    // Output and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluctr_q    <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            zero_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            aluctr_q    <= aluctr_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            zero_q      <= zero_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign bus.in_ready  = mdu_idle;
    assign bus.busy      = ~mdu_idle;
    assign bus.aluctr    = aluctr_q;
    assign bus.result    = result_q;
    assign bus.out_valid = out_valid_q;
    assign bus.illegal   = illegal_q;
    assign bus.zero      = zero_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: doc/alu_exec_mdu.md
# alu_exec_mdu

Parametrised execute-stage unit combining ALU control decode, a registered ALU, and an iterative multiply/divide unit (MDU) with HI/LO registers. It sits between the decode stage (aluop, funct, operands) and writeback. It accepts one operation per handshake. Single-cycle ops return a result after one cycle. mult/div ops occupy the unit for WIDTH+1 cycles and write HI/LO.

## Interface
- WIDTH, 32: datapath width. Must be a power of two, ≥ 8.
- CNT_W, $clog2(WIDTH): iteration counter width. Localparam, derived.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation present on the inputs.
- in_ready  out  1  unit can accept. Equals (state == IDLE).
- aluop  in  2  00 = lw/sw add, 01 = beq sub, 11 = addi add, 10 = R-type (decode funct).
- funct  in  6  R-type function field.
- op_a, op_b  in  WIDTH  rs / rt-or-immediate operands.
- aluctr  out  4  registered decoded control of the last accepted op.
- out_valid  out  1  one-cycle pulse: result is valid.
- result  out  WIDTH  registered ALU / mfhi / mflo result.
- zero  out  1  result == 0, qualified by out_valid.
- illegal  out  1  one-cycle pulse with out_valid for an undefined funct.
- hi, lo  out  WIDTH  architectural HI/LO registers.
- busy  out  1  MDU in progress (= !in_ready).

## Operation
- Accept happens when in_valid && in_ready. Nothing is latched otherwise.
- aluctr codes:
  - add 0010, sub 0110, and 0000, or 0001, slt 0111, nor 1100, sltu 1000
  - mfhi 1101, mflo 1110, mdu 0011, illegal 1111
- aluop 00 or 11 gives add. aluop 01 gives sub.
- aluop 10 decodes funct:
  - 100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 100111 nor
  - 101010 slt (signed), 101011 sltu
  - 010000 mfhi, 010010 mflo
  - 011000 mult, 011001 multu, 011010 div, 011011 divu
  - any other funct: illegal. result = 0, illegal = 1, out_valid = 1.
- Arithmetic wraps modulo 2^WIDTH. No overflow trap.
- slt/sltu produce result = {WIDTH-1 zeros, bit}.
- mfhi/mflo return the current hi/lo.
- mult/multu: {hi,lo} = 2·WIDTH-bit product.
- div/divu: lo = quotient, hi = remainder.
  - Signed ops use magnitudes plus a final fixup: quotient negated if sign(a)^sign(b); remainder takes sign(a).
  - Divide by zero: lo = all ones, hi = op_a. Same latency as a normal divide.
  - Signed -2^(WIDTH-1) / -1: lo = 0x80..0, hi = 0.
- MDU ops never raise out_valid; completion is seen as busy falling.
- FSM states:
  - IDLE
    - single-cycle op accepted → stay in IDLE.
    - mult/div accepted → MUL or DIV, cnt = 0.
  - MUL: shift-add, one bit per cycle. After cnt == WIDTH-1 → FIX.
  - DIV: restoring, one bit per cycle. After cnt == WIDTH-1 → FIX.
  - FIX: apply sign correction, write hi/lo → IDLE.
- hi/lo keep their old values until the FIX cycle.

## Timing
- Reset values:
  - state IDLE, in_ready 1, busy 0
  - out_valid 0, illegal 0, zero 0
  - result 0, aluctr 0000, hi 0, lo 0
- Single-cycle op accepted at edge N: result, aluctr, out_valid visible after edge N+1. Back-to-back issue gives one result per cycle.
- MDU op accepted at edge N:
  - busy high from N+1 through N+WIDTH+1.
  - hi/lo updated at edge N+WIDTH+1.
  - in_ready high again after edge N+WIDTH+1.
- An mfhi issued the cycle busy drops reads the new hi.
- in_valid while busy is ignored. The upstream holds the op (stall).
- Asserting rst_n low mid-MDU aborts immediately: all registers return to reset values, hi/lo cleared.
- out_valid is never asserted in two consecutive cycles unless two accepts occur in consecutive cycles.

## Structure
- Package mips_alu_pkg holds:
  - aluop encodings
  - funct localparams
  - aluctr code localparams
  - FSM state enum (IDLE, MUL, DIV, FIX)
- Sub-module mdu_iter (WIDTH parameter) holds the MUL/DIV datapath, cnt, and sign fixup. Handshake: start/op/done.
- The top level owns decode, the ALU, and the output registers.

## Test plan
- Reset, then aluop=10, funct=100000, a=7, b=5 → one cycle later result=12, aluctr=0010, out_valid=1 for one cycle.
- aluop=10, funct=101010, a=0xFFFFFFFF, b=1 → result=1. Same operands with sltu (101011) → result=0.
- mult, a=0xFFFFFFFE (-2), b=3 → busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Next op mfhi → result=0xFFFFFFFF.
- div, a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu, a=7, b=0 → lo=0xFFFFFFFF, hi=7.
- in_valid held with add during a divu: not accepted until in_ready returns. Then add completes one cycle later.
- funct=111111 → illegal=1, result=0, aluctr=1111.
- rst_n pulsed low at cycle 10 of a mult → in_ready=1, hi=lo=0 immediately.
